// File: rtl/coprocessor_pio_ctrl_irq.sv
// Avalon-MM PIO slave: control outputs with set/clear aliases and self-clearing pulse bits,
// synchronised status inputs with rising-edge capture and a maskable level interrupt.
module coprocessor_pio_ctrl_irq #(
  parameter int unsigned          OUT_WIDTH   = 3,
  parameter int unsigned          IN_WIDTH    = 2,
  parameter logic [OUT_WIDTH-1:0] PULSE_MASK  = OUT_WIDTH'(1),
  parameter logic [OUT_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic [OUT_WIDTH-1:0] out_port,
  output logic                 irq
);

  localparam logic [OUT_WIDTH-1:0] DataReset = RESET_VALUE & ~PULSE_MASK;

  logic [OUT_WIDTH-1:0] r_data_out;
  logic [IN_WIDTH-1:0]  r_sync1, r_sync2, r_prev;
  logic [IN_WIDTH-1:0]  r_irq_mask, r_edge_cap;

  logic                 w_wr;
  logic [OUT_WIDTH-1:0] w_wd_out, w_hold, w_data_nx;
  logic [IN_WIDTH-1:0]  w_wd_in, w_mask_nx, w_w1c, w_rise;

  assign w_wr     = chipselect & ~write_n;
  assign w_wd_out = writedata[OUT_WIDTH-1:0];
  assign w_wd_in  = writedata[IN_WIDTH-1:0];
  // Pulse bits drop out of the hold value, so they fall unless this cycle's write sets them again.
  assign w_hold   = r_data_out & ~PULSE_MASK;
  assign w_rise   = r_sync2 & ~r_prev;

  always_comb begin
    w_data_nx = w_hold;
    w_mask_nx = r_irq_mask;
    w_w1c     = '0;
    if (w_wr) begin
      case (address)
        3'd0:    w_data_nx = w_wd_out;
        3'd2:    w_mask_nx = w_wd_in;
        3'd3:    w_w1c     = w_wd_in;
        3'd4:    w_data_nx = w_hold | w_wd_out;
        3'd5:    w_data_nx = w_hold & ~w_wd_out;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= DataReset;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_irq_mask <= '0;
      r_edge_cap <= '0;
    end else begin
      r_data_out <= w_data_nx;
      r_sync1    <= in_port;
      r_sync2    <= r_sync1;
      r_prev     <= r_sync2;
      r_irq_mask <= w_mask_nx;
      // A new rise beats a simultaneous W1C so no event is lost.
      r_edge_cap <= (r_edge_cap & ~w_w1c) | w_rise;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[OUT_WIDTH-1:0] = r_data_out;
      3'd1:    readdata[IN_WIDTH-1:0]  = r_sync2;
      3'd2:    readdata[IN_WIDTH-1:0]  = r_irq_mask;
      3'd3:    readdata[IN_WIDTH-1:0]  = r_edge_cap;
      default: readdata = '0;
    endcase
  end

  assign out_port = r_data_out;
  assign irq      = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_coprocessor_pio_ctrl_irq.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized bus/status
// traffic compared every cycle against a history-based behavioural model.
module tb_coprocessor_pio_ctrl_irq;

  localparam logic [2:0] PM = 3'b001;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [1:0]  in_port = '0;
  logic [2:0]  out_port;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  coprocessor_pio_ctrl_irq #(
    .OUT_WIDTH  (3),
    .IN_WIDTH   (2),
    .PULSE_MASK (3'b001),
    .RESET_VALUE(3'b000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Status inputs are kept as a history of edge samples; in_sync after edge n is the sample of
  // edge n-1, and anything sampled before reset release reads as zero.
  int         m_n = 0;
  logic [1:0] m_hist [0:7];
  logic [2:0] m_level = '0;   // persistent (non-pulse) out bits
  logic [2:0] m_pulse = '0;   // pulse bits set by the write at the last edge
  logic [1:0] m_mask = '0;
  logic [1:0] m_cap = '0;

  logic       mw_wr;
  logic [1:0] mw_w1c;
  logic [2:0] mw_level_nx, mw_pulse_nx;

  function automatic logic [1:0] samp(input int k);
    if (k < 1) return 2'b00;
    return m_hist[3'(k)];
  endfunction

  always_comb begin
    mw_wr       = chipselect && !write_n;
    mw_w1c      = '0;
    mw_level_nx = m_level;
    mw_pulse_nx = '0;
    if (mw_wr) begin
      case (address)
        3'd0: begin
          mw_level_nx = writedata[2:0] & ~PM;
          mw_pulse_nx = writedata[2:0] & PM;
        end
        3'd3: mw_w1c = writedata[1:0];
        3'd4: begin
          mw_level_nx = m_level | (writedata[2:0] & ~PM);
          mw_pulse_nx = writedata[2:0] & PM;
        end
        3'd5: mw_level_nx = m_level & ~writedata[2:0];
        default: ;
      endcase
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_n     <= 0;
      m_level <= '0;
      m_pulse <= '0;
      m_mask  <= '0;
      m_cap   <= '0;
    end else begin
      m_n                  <= m_n + 1;
      m_hist[3'(m_n + 1)]  <= in_port;
      m_cap                <= (m_cap & ~mw_w1c) | (samp(m_n - 1) & ~samp(m_n - 2));
      if (mw_wr && address == 3'd2) m_mask <= writedata[1:0];
      m_level              <= mw_level_nx;
      m_pulse              <= mw_pulse_nx;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    case (a)
      3'd0:    return {29'b0, m_level | m_pulse};
      3'd1:    return {30'b0, samp(m_n - 1)};
      3'd2:    return {30'b0, m_mask};
      3'd3:    return {30'b0, m_cap};
      default: return 32'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    check("model_out_port", {29'b0, out_port}, {29'b0, m_level | m_pulse});
    check("model_irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
    check("model_readdata", readdata, exp_rd(address));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  initial begin
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // T1: reset mid-run
    bus_write(3'd0, 32'h6);
    check("t1_pre_out", {29'b0, out_port}, 32'h6);
    reset_n = 1'b0;
    #1;
    check("t1_out", {29'b0, out_port}, 32'h0);
    check("t1_irq", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      check("t1_read", readdata, 32'h0);
    end
    tick();
    reset_n = 1'b1;
    tick();

    // T2: data and aliases
    bus_write(3'd0, 32'h6);
    check("t2_data", {29'b0, out_port}, 32'h6);
    bus_write(3'd4, 32'h1);
    check("t2_set_pulse", {29'b0, out_port}, 32'h7);
    tick();
    check("t2_after_pulse", {29'b0, out_port}, 32'h6);
    bus_write(3'd5, 32'h4);
    check("t2_clr", {29'b0, out_port}, 32'h2);

    // T3: pulse width
    bus_write(3'd0, 32'h1);
    check("t3_pulse_hi", {29'b0, out_port}, 32'h1);
    tick();
    check("t3_pulse_lo", {29'b0, out_port}, 32'h0);
    bus_write(3'd0, 32'h1);
    check("t3_b2b_1", {29'b0, out_port}, 32'h1);
    bus_write(3'd0, 32'h1);
    check("t3_b2b_2", {29'b0, out_port}, 32'h1);
    tick();
    check("t3_b2b_lo", {29'b0, out_port}, 32'h0);

    // T4: edge capture and irq
    bus_write(3'd2, 32'h1);
    in_port = 2'b01;
    tick();
    tick();
    check("t4_irq_early", {31'b0, irq}, 32'h0);
    tick();
    check("t4_irq", {31'b0, irq}, 32'h1);
    rd_check("t4_edgecap", 3'd3, 32'h1);
    bus_write(3'd3, 32'h1);
    check("t4_irq_w1c", {31'b0, irq}, 32'h0);

    // T5: W1C colliding with a new rise
    in_port = 2'b11;
    repeat (3) tick();
    rd_check("t5_cap_pre", 3'd3, 32'h2);
    rd_check("t5_status", 3'd1, 32'h3);
    in_port = 2'b01;
    repeat (3) tick();
    in_port = 2'b11;
    tick();
    tick();
    bus_write(3'd3, 32'h2);
    rd_check("t5_collision", 3'd3, 32'h2);

    // T6: masked capture, then unmask
    bus_write(3'd3, 32'h3);
    bus_write(3'd2, 32'h0);
    in_port = 2'b01;
    repeat (3) tick();
    in_port = 2'b11;
    repeat (3) tick();
    check("t6_irq_masked", {31'b0, irq}, 32'h0);
    rd_check("t6_cap", 3'd3, 32'h2);
    bus_write(3'd2, 32'h2);
    check("t6_irq_unmask", {31'b0, irq}, 32'h1);

    // Randomized traffic, checked every cycle by the model comparator
    for (int i = 0; i < 3000; i++) begin
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom);
      write_n    = 1'($urandom);
      writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ 2'($urandom);
      reset_n    = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
